// File: rtl/radix4_digit_collector.sv
// Rebuilds a two's-complement integer from a serial stream of signed radix-4
// digits (LSD first), framed by start and returned over a valid/ready handshake.
module radix4_digit_collector #(
  parameter int WIDTH = 8,
  parameter int NDIG  = WIDTH / 2 + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             d_valid,
  input  logic [2:0]       d,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [WIDTH+2:0] result,
  output logic             err
);

  localparam int RW = WIDTH + 3;
  localparam int CW = $clog2(NDIG + 1);

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    DONE
  } state_t;

  state_t state, state_next;

  logic [RW-1:0] acc;
  logic [CW-1:0] count;
  logic          digit_legal;
  logic          frame_start;
  logic          accept;
  logic          last_digit;
  logic [RW-1:0] digit_ext;
  logic [RW-1:0] term;
  logic [RW-1:0] sum;

  // Illegal codes (+3, -4, -3) still use a digit slot but add nothing.
  assign digit_legal = !((d == 3'b011) || (d == 3'b100) || (d == 3'b101));
  assign digit_ext   = digit_legal ? {{(RW-3){d[2]}}, d} : '0;
  assign term        = digit_ext << {count, 1'b0};
  assign sum         = acc + term;

  assign frame_start = start && ((state == IDLE) || (state == COLLECT) ||
                                 ((state == DONE) && out_ready));
  assign accept      = (state == COLLECT) && d_valid && !start;
  assign last_digit  = (count == CW'(NDIG - 1));

  assign busy      = (state == COLLECT);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (start) begin
          state_next = COLLECT;
        end else if (accept && last_digit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = start ? COLLECT : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // result is a separate register so it survives the next frame's accumulation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc    <= '0;
      count  <= '0;
      result <= '0;
      err    <= 1'b0;
    end else if (frame_start) begin
      acc   <= '0;
      count <= '0;
      err   <= 1'b0;
    end else if (accept) begin
      acc   <= sum;
      count <= count + 1'b1;
      if (!digit_legal) begin
        err <= 1'b1;
      end
      if (last_digit) begin
        result <= sum;
      end
    end
  end

endmodule

// File: doc/radix4_digit_collector.md
Name: radix4_digit_collector

Overview:
- Inverse of the serial radix-4 recoder shift register: accepts one signed radix-4 digit per cycle, least-significant digit first, and rebuilds the two's-complement integer value.
- Sits on the multiplier-side digit stream. Used as a scoreboard/loopback decoder and for reconstructing recoded operands.
- Frame framing is controlled by a start pulse. The result is returned over a valid/ready handshake.

Parameters:
- WIDTH, 8, operand width of the recoded source value; must be even and ≥ 4.
- NDIG, WIDTH/2+1, digits per frame: one per bit pair plus the final carry digit.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  begins a new frame; single-cycle pulse.
- d_valid  in  1  digit on d is valid this cycle.
- d  in  3  signed two's-complement digit; legal values -2..+2.
- out_ready  in  1  consumer accepts result.
- busy  out  1  high in COLLECT.
- out_valid  out  1  result available (DONE state).
- result  out  WIDTH+3  signed value, sum of d_i·4^i for i = 0..NDIG-1.
- err  out  1  sticky: an illegal digit was received in the current frame.

Behaviour:
- Reset (async): state=IDLE; busy=0, out_valid=0, result=0, err=0; internal accumulator and digit counter cleared. Reset mid-frame discards the frame entirely.
- FSM states: IDLE, COLLECT, DONE.
- IDLE:
  - start=1 → COLLECT next cycle; accumulator=0, count=0, err=0.
  - d_valid is ignored in IDLE.
- COLLECT:
  - Each cycle with d_valid=1 accepts d as digit index = count, then increments count.
  - d_valid=0 stalls; no state change.
  - Legal d ∈ {-2,-1,0,+1,+2} adds d·4^count to the accumulator.
  - Illegal d (3'b011, 3'b100, 3'b101, i.e. +3, -4, -3) contributes 0, still consumes a digit slot, and sets err=1.
  - On acceptance of digit NDIG-1 → DONE next cycle. result is loaded with the final value and out_valid=1 on that same edge. Latency is 1 cycle from the last digit to out_valid.
  - start=1 in COLLECT restarts the frame: partial sum discarded, count=0, err=0; d_valid in that cycle is ignored.
- Arithmetic: the accumulator is WIDTH+3 bits signed; full-range sums ±2·(4^NDIG−1)/3 fit without overflow. Any shift/add or Horner structure is acceptable, provided the result is exact.
- DONE:
  - out_valid=1; result and err are held stable until the transfer completes.
  - out_ready=1 completes the transfer. Next state is IDLE, or COLLECT if start=1 in the same cycle (back-to-back frames; err cleared).
  - start with out_ready=0 is ignored.
  - d_valid is ignored in DONE.
- After the transfer, result keeps its last value and out_valid=0. err stays asserted until the next start is accepted.
- busy=1 exactly while in COLLECT.

Test Plan:
- WIDTH=8, start, then digits +1,+1,-1,-1,+1 on consecutive cycles (recoding of 0xB5) → out_valid=1 one cycle after the 5th digit; result=181; err=0; busy low from the same edge.
- Digits -2 ×5 → result=-682 (11-bit 0x556); digits +2 ×5 → result=+682 (0x2AA); no overflow.
- Digits 0,+2,idle,idle,-1,0,+1 (d_valid low on the idle cycles) → stalls honoured; result = 8−16+256 = 248; out_valid arrives only after the 5th accepted digit.
- Digit stream containing 3'b011 at index 2 with the others 0 → err=1 and result=0 at out_valid. Next start clears err.
- start after 3 digits, then a fresh 5-digit frame +1,0,0,0,0 → result=1; the partial frame is discarded.
- Hold out_ready=0 for 4 cycles in DONE while pulsing start → result stable, start ignored. Then out_ready=1 with start=1 → busy=1 next cycle. Separately, assert rst mid-COLLECT → all outputs 0 immediately, state IDLE.
